// File: rtl/bayer_demosaic_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bayer_demosaic_stream                                                      |
// | Streaming bilinear Bayer-to-RGBA demosaic, two internal line buffers.      |
// | Optional build macro: DEMOSAIC_ROUND_EN (round-half-up interpolation).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bayer_demosaic_stream #(
    parameter int         IMG_W     = 40,
    parameter int         IMG_H     = 30,
    parameter int         PIX_W     = 8,
    parameter logic [1:0] CFA_PHASE = 2'd0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PIX_W-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*PIX_W-1:0]   out_pixel,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof
);
    localparam int             XW     = $clog2(IMG_W);
    localparam int             YW     = $clog2(IMG_H);
    localparam int             SW     = PIX_W + 2;
    localparam logic [XW-1:0]  X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]  Y_LAST = YW'(IMG_H - 1);
`ifdef DEMOSAIC_ROUND_EN
    localparam logic [SW-1:0]  BIAS_HALF = SW'(1);
    localparam logic [SW-1:0]  BIAS_QRTR = SW'(2);
`else
    localparam logic [SW-1:0]  BIAS_HALF = SW'(0);
    localparam logic [SW-1:0]  BIAS_QRTR = SW'(0);
`endif

    typedef enum logic [1:0] {FILL = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;
    state_t state, state_nxt;

    logic                     run;
    logic [XW-1:0]            in_x, ox;
    logic [YW-1:0]            in_y, oy;
    logic                     in_fire, drain_step, step, emit, eof_xfer;
    logic [PIX_W-1:0]         lb_mid [IMG_W];
    logic [PIX_W-1:0]         lb_top [IMG_W];
    logic [2:0][PIX_W-1:0]    col1, col2, col_new, hl, hc, hr;
    logic [1:0]               rt, rb, code;
    logic [SW-1:0]            sum_c, sum_h, sum_v, sum_x, sum_n;
    logic [PIX_W-1:0]         h2, v2, x4, n4, cc, r, g, b;

    // Local reset: asserts with reset_n, releases on the next clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) run <= 1'b0;
        else          run <= 1'b1;
    end

    always_comb begin
        in_ready = 1'b0;
        case (state)
            FILL:    in_ready = run;
            STREAM:  in_ready = run && (!out_valid || out_ready);
            default: in_ready = 1'b0;
        endcase
    end

    assign in_fire    = in_valid && in_ready;
    assign drain_step = (state == DRAIN) && (!out_valid || (out_ready && !out_eof));
    assign step       = in_fire || drain_step;
    assign emit       = ((state == STREAM) && in_fire) || drain_step;
    assign eof_xfer   = (state == DRAIN) && out_valid && out_ready && out_eof;

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (in_fire && in_x == '0 && in_y == YW'(1)) state_nxt = STREAM;
            STREAM:  if (in_fire && in_x == X_LAST && in_y == Y_LAST) state_nxt = DRAIN;
            DRAIN:   if (eof_xfer) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge run) begin
        if (!run) begin
            state <= FILL;
            in_x  <= '0;
            in_y  <= '0;
            ox    <= '0;
            oy    <= '0;
        end else begin
            state <= state_nxt;
            if (eof_xfer) begin
                in_x <= '0;
                in_y <= '0;
                ox   <= '0;
                oy   <= '0;
            end else begin
                if (step) begin
                    if (in_x == X_LAST) begin
                        in_x <= '0;
                        in_y <= (in_y == Y_LAST) ? '0 : in_y + YW'(1);
                    end else begin
                        in_x <= in_x + XW'(1);
                    end
                end
                if (emit) begin
                    if (ox == X_LAST) begin
                        ox <= '0;
                        oy <= (oy == Y_LAST) ? '0 : oy + YW'(1);
                    end else begin
                        ox <= ox + XW'(1);
                    end
                end
            end
        end
    end

    // Each line buffer is a W-deep delay line; drain steps keep them shifting.
    always_ff @(posedge clk) begin
        if (step) begin
            lb_mid[in_x] <= in_data;
            lb_top[in_x] <= lb_mid[in_x];
            col2         <= col1;
            col1         <= col_new;
        end
    end

    assign col_new = {in_data, lb_mid[in_x], lb_top[in_x]};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            hl[i] = (ox == '0)     ? col_new[i] : col2[i];
            hc[i] = col1[i];
            hr[i] = (ox == X_LAST) ? col2[i]    : col_new[i];
        end
        rt    = (oy == '0)     ? 2'd2 : 2'd0;
        rb    = (oy == Y_LAST) ? 2'd0 : 2'd2;
        sum_c = SW'(hc[1]);
        sum_h = SW'(hl[1]) + SW'(hr[1]);
        sum_v = SW'(hc[rt]) + SW'(hc[rb]);
        sum_x = SW'(hl[rt]) + SW'(hr[rt]) + SW'(hl[rb]) + SW'(hr[rb]);
        sum_n = sum_h + sum_v;
        cc    = PIX_W'(sum_c);
        h2    = PIX_W'((sum_h + BIAS_HALF) >> 1);
        v2    = PIX_W'((sum_v + BIAS_HALF) >> 1);
        x4    = PIX_W'((sum_x + BIAS_QRTR) >> 2);
        n4    = PIX_W'((sum_n + BIAS_QRTR) >> 2);
        code  = CFA_PHASE ^ {oy[0], ox[0]};
        r     = cc;
        g     = n4;
        b     = x4;
        case (code)
            2'd0: begin r = cc; g = n4; b = x4; end
            2'd1: begin r = h2; g = cc; b = v2; end
            2'd2: begin r = v2; g = cc; b = h2; end
            default: begin r = x4; g = n4; b = cc; end
        endcase
    end

    always_ff @(posedge clk or negedge run) begin
        if (!run) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_pixel <= {r, g, b, {PIX_W{1'b1}}};
            out_sof   <= (ox == '0) && (oy == '0);
            out_eol   <= (ox == X_LAST);
            out_eof   <= (ox == X_LAST) && (oy == Y_LAST);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bayer_demosaic_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bayer_demosaic_stream                                                   |
// | Scoreboard bench for bayer_demosaic_stream on a 4x4, CFA phase 0 frame.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bayer_demosaic_stream;
    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pixel;
    logic        out_sof, out_eol, out_eof;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [34:0] exp_q[$];
    logic [7:0]  img[W*H];
    logic        bp_go = 1'b0;
    logic        bp_done = 1'b0;
    logic        stalled = 1'b0;
    logic [34:0] held;

    always #5 clk = ~clk;

    bayer_demosaic_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .CFA_PHASE(2'd0)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic int mir(input int v, input int lim);
        if (v < 0) return 1;
        if (v > lim - 1) return lim - 2;
        return v;
    endfunction

    function automatic int px(input int x, input int y);
        return int'(img[mir(y, H) * W + mir(x, W)]);
    endfunction

    function automatic logic [31:0] model(input int x, input int y);
        int c, h, v, d, n, rh, rq, r, g, b;
        logic [1:0] code;
`ifdef DEMOSAIC_ROUND_EN
        rh = 1; rq = 2;
`else
        rh = 0; rq = 0;
`endif
        c = px(x, y);
        h = px(x - 1, y) + px(x + 1, y);
        v = px(x, y - 1) + px(x, y + 1);
        d = px(x - 1, y - 1) + px(x + 1, y - 1) + px(x - 1, y + 1) + px(x + 1, y + 1);
        n = h + v;
        code = {y[0], x[0]};
        case (code)
            2'd0: begin r = c; g = (n + rq) / 4; b = (d + rq) / 4; end
            2'd1: begin r = (h + rh) / 2; g = c; b = (v + rh) / 2; end
            2'd2: begin r = (v + rh) / 2; g = c; b = (h + rh) / 2; end
            default: begin r = (d + rq) / 4; g = (n + rq) / 4; b = c; end
        endcase
        return {r[7:0], g[7:0], b[7:0], 8'hFF};
    endfunction

    // Called and returns at posedge+1; in_ready is sampled on the negedge before the edge.
    task automatic send(input logic [7:0] d);
        int   t;
        logic ok;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 500);
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: sample %h not accepted, required accept", d);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL output_timeout: %0d outputs missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // kind 0: all 0x80, kind 1: all 0xFF, kind 2: ramp x+4y
    task automatic run_frame(input int kind, input int bp_at);
        logic [31:0] e;
        for (int i = 0; i < W * H; i++)
            img[i] = (kind == 0) ? 8'h80 : (kind == 1) ? 8'hFF : 8'(i);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (kind == 0)      e = 32'h808080FF;
                else if (kind == 1) e = 32'hFFFFFFFF;
                else if (x == 0 && y == 0)
`ifdef DEMOSAIC_ROUND_EN
                    e = 32'h000305FF;
`else
                    e = 32'h000205FF;
`endif
                else if (x == 1 && y == 1) e = 32'h050505FF;
                else if (x == 3 && y == 3)
`ifdef DEMOSAIC_ROUND_EN
                    e = 32'h0A0D0FFF;
`else
                    e = 32'h0A0C0FFF;
`endif
                else e = model(x, y);
                exp_q.push_back({e, (x == 0 && y == 0), (x == W - 1), (x == W - 1 && y == H - 1)});
            end
        end
        for (int i = 0; i < W * H; i++) begin
            if (i == bp_at) bp_go = 1'b1;
            send(img[i]);
        end
        wait_empty();
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks stall stability.
    always @(negedge clk) begin
        if (reset_n) begin
            if (stalled) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_pixel", {29'd0, out_pixel, out_sof, out_eol, out_eof}, {29'd0, held});
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                held    = {out_pixel, out_sof, out_eol, out_eof};
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_output: got %h, required none", out_pixel);
                end else begin
                    check("pixel_flags", {29'd0, out_pixel, out_sof, out_eol, out_eof},
                          {29'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Sink: always ready except one 5-cycle hold while a pixel is presented.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_go && !bp_done && out_valid) begin
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
                bp_done   = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation still running, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pixel", 64'(out_pixel), 64'd0);
        check("rst_flags", {61'd0, out_sof, out_eol, out_eof}, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_first_cycle", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("in_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(2, -1);
        run_frame(2, 9);

        // Abandon a frame after 7 samples: pixels (0,0) and (1,0) are already due.
        for (int i = 0; i < W * H; i++) img[i] = 8'h80;
        exp_q.push_back({32'h808080FF, 1'b1, 1'b0, 1'b0});
        exp_q.push_back({32'h808080FF, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 7; i++) send(8'h80);
        wait_empty();
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid_a", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("midrst_out_valid_b", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_frame(0, -1);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
